// File: rtl/fetch_pkg.sv
// Purpose : shared definitions for the instruction prefetch queue.
// Contents: fetch FSM state encoding and the halt opcode value.
// Users   : fetch_prefetch_queue (top) and its testbench.
package fetch_pkg;

  // IDLE: no request outstanding, WAIT: request outstanding and wanted,
  // DROP: request outstanding but its data is stale, HALT: halt opcode fetched.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [3:0] HALT_OPCODE = 4'hF;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose : circular queue holding prefetched {pc, instruction} entries.
// Latency : a pushed entry is visible at head_data the cycle after the push.
// Backpr. : caller must not push when full or pop when empty; flush wins over push/pop.
// Ports   : clk, rst (async, active high); push/push_data, pop, flush in;
//           head_data, full, empty, count (0..DEPTH) out.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   cnt;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + (PTR_W+1)'(1);
      else if (pop && !push) cnt <= cnt - (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: the head is only looked at when count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == DEPTH[PTR_W:0]);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Purpose : instruction fetch unit; keeps one memory request in flight and
//           buffers returned instructions in a DEPTH-entry prefetch queue.
// Latency : mem_rvalid -> inst_valid is 1 cycle (0 cycles with FETCH_BYPASS_EN
//           when the queue is empty).
// Backpr. : inst_ready low stalls decode; fetching stops while the queue is full;
//           mem_rvalid low holds mem_req/mem_addr; redirect flushes and refetches.
// Ports   : clk, rst (async, active high); inst_ready, redirect/redirect_pc,
//           mem_rvalid/mem_rdata in; mem_req/mem_addr, inst_valid/inst_data/
//           inst_pc, next_pc, hlt out.
// Config  : define FETCH_BYPASS_EN to present a response straight to decode
//           when the queue is empty.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              hlt
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam int                ENT_W   = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] PC0     = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] req_addr, req_addr_nxt;
  logic              req, req_nxt;

  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  head;
  logic [CNT_W-1:0]  occ_after;
  logic              rsp_ok, rsp_halt, bypass, pop_fire;

  // A response that will actually be kept: only in WAIT, and not when a
  // redirect makes it stale in the same cycle.
  assign rsp_ok   = (state == WAIT) && mem_rvalid && !redirect;
  assign rsp_halt = (mem_rdata[DATA_W-1 -: 4] == HALT_OPCODE);

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty && rsp_ok;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    inst_valid = !fifo_empty;
    inst_data  = fifo_empty ? '0 : head[DATA_W-1:0];
    inst_pc    = fifo_empty ? '0 : head[ENT_W-1 -: ADDR_W];
    if (bypass) begin
      inst_valid = 1'b1;
      inst_data  = mem_rdata;
      inst_pc    = fetch_pc;
    end
  end

  assign next_pc  = inst_pc + STEP;
  assign hlt      = inst_valid && (inst_data[DATA_W-1 -: 4] == HALT_OPCODE);
  assign pop_fire = inst_valid && inst_ready;

  // A bypassed entry taken by decode never enters the queue.
  assign fifo_pop  = pop_fire && !bypass;
  assign fifo_push = rsp_ok && !(bypass && inst_ready);

  // Occupancy after this cycle's push/pop; decides whether WAIT can
  // chain straight into the next request.
  assign occ_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({fetch_pc, mem_rdata}),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= PC0;
      req_addr <= PC0;
      req      <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_addr <= req_addr_nxt;
      req      <= req_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_addr_nxt = req_addr;
    req_nxt      = req;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
        end else if (!fifo_full) begin
          state_nxt    = WAIT;
          req_nxt      = 1'b1;
          req_addr_nxt = fetch_pc;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
          if (mem_rvalid) begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end else begin
            // Request is still in flight; keep the bus stable and eat its data.
            state_nxt = DROP;
          end
        end else if (mem_rvalid) begin
          fetch_pc_nxt = fetch_pc + STEP;
          if (rsp_halt) begin
            state_nxt = HALT;
            req_nxt   = 1'b0;
          end else if (occ_after < DEPTH_C) begin
            req_addr_nxt = fetch_pc + STEP;
          end else begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end
        end
      end
      DROP: begin
        if (redirect) fetch_pc_nxt = redirect_pc;
        if (mem_rvalid) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      HALT: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
          state_nxt    = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  assign mem_req  = req;
  assign mem_addr = req_addr;

endmodule
